// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the E stage.
//
// Executes the MDU commands issued by the decoder and owns the
// architectural HI/LO registers. The 64-bit result is computed at the
// acceptance edge and parked in pending registers. A down-counter then
// holds Busy high for the operation's latency. When the counter reaches
// terminal count, the pending value is committed to HI/LO.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   MDUEN    - command valid from the E-stage pipeline register
//   MDUCtrl  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//              7 reserved (treated as none)
//   Cancel   - E-stage instruction killed; suppresses this cycle's command
//   A, B     - rs / rt operands (forwarded)
//   Busy     - operation in flight (registered)
//   HI, LO   - architectural HI/LO registers
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation in flight; Busy=0; commands may be accepted
// RUN   | result pending; Busy=1; counter counts down to terminal count

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MDUEN,
  input  logic [2:0]  MDUCtrl,
  input  logic        Cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] CMD_MULT  = 3'd1;
  localparam logic [2:0] CMD_MULTU = 3'd2;
  localparam logic [2:0] CMD_DIV   = 3'd3;
  localparam logic [2:0] CMD_DIVU  = 3'd4;
  localparam logic [2:0] CMD_MTHI  = 3'd5;
  localparam logic [2:0] CMD_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      pend_hi, pend_hi_nxt;
  logic [31:0]      pend_lo, pend_lo_nxt;
  logic [31:0]      hi_q, hi_nxt;
  logic [31:0]      lo_q, lo_nxt;

  logic             accept;
  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic             div_signed;
  logic             neg_num;
  logic             neg_den;
  logic [31:0]      num_mag;
  logic [31:0]      den_mag;
  logic [31:0]      den_safe;
  logic [31:0]      quo_mag;
  logic [31:0]      rem_mag;
  logic [31:0]      quo;
  logic [31:0]      rem;

  // Multiply: the low 64 bits of a product of sign-extended operands
  // equal the signed 32x32 product.
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

  // Divide: a single unsigned divider on operand magnitudes serves both
  // div and divu. The signed overflow case 0x80000000 / -1 falls out
  // naturally: the magnitude 0x80000000 / 1 re-negates to 0x80000000
  // with remainder 0.
  assign div_signed = (MDUCtrl == CMD_DIV);
  assign neg_num    = div_signed & A[31];
  assign neg_den    = div_signed & B[31];
  assign num_mag    = neg_num ? (~A + 32'd1) : A;
  assign den_mag    = neg_den ? (~B + 32'd1) : B;
  // The divide-by-zero result is substituted below. Keep the divider
  // input nonzero so it never sees 0.
  assign den_safe   = (den_mag == 32'd0) ? 32'd1 : den_mag;
  assign quo_mag    = num_mag / den_safe;
  assign rem_mag    = num_mag % den_safe;

  always_comb begin
    quo = (neg_num ^ neg_den) ? (~quo_mag + 32'd1) : quo_mag;
    rem = neg_num ? (~rem_mag + 32'd1) : rem_mag;
    if (B == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = A;
    end
  end

  assign accept = (state == ST_IDLE) && MDUEN && !Cancel &&
                  (MDUCtrl >= CMD_MULT) && (MDUCtrl <= CMD_MTLO);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    hi_nxt      = hi_q;
    lo_nxt      = lo_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (MDUCtrl)
            CMD_MULT: begin
              pend_hi_nxt = prod_s[63:32];
              pend_lo_nxt = prod_s[31:0];
              cnt_nxt     = MULT_LOAD;
              state_nxt   = ST_RUN;
            end
            CMD_MULTU: begin
              pend_hi_nxt = prod_u[63:32];
              pend_lo_nxt = prod_u[31:0];
              cnt_nxt     = MULT_LOAD;
              state_nxt   = ST_RUN;
            end
            CMD_DIV, CMD_DIVU: begin
              pend_hi_nxt = rem;
              pend_lo_nxt = quo;
              cnt_nxt     = DIV_LOAD;
              state_nxt   = ST_RUN;
            end
            CMD_MTHI: hi_nxt = A;
            CMD_MTLO: lo_nxt = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // Commands arriving here are ignored; stall logic keeps them out.
        if (cnt == '0) begin
          hi_nxt    = pend_hi;
          lo_nxt    = pend_lo;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
    end
  end

  assign Busy = (state == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit.
// Expected HI/LO values are pushed when a command is driven and popped
// when the unit finishes (Busy falls, or the next cycle for mthi/mtlo).

module tb_md_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MDUEN;
  logic [2:0]  MDUCtrl;
  logic        Cancel;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  md_unit #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .MDUEN  (MDUEN),
    .MDUCtrl(MDUCtrl),
    .Cancel (Cancel),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers: no 32-bit overflow cases.
  function automatic logic [63:0] model_result(input logic [2:0] ctrl,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, pu;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = {m_hi, m_lo};
    case (ctrl)
      3'd1: res = sa * sb;
      3'd2: begin
        pu  = ua * ub;
        res = pu;
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: ;
    endcase
    return res;
  endfunction

  task automatic mdu_op(input logic [2:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input bit inject_mtlo);
    int          cycles;
    int          busy_n;
    bit          hold_ok;
    logic [63:0] want;
    sb_q.push_back(model_result(ctrl, a, b));
    cycles = (ctrl <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
    @(negedge clk);
    MDUEN = 1'b1; MDUCtrl = ctrl; A = a; B = b; Cancel = 1'b0;
    @(negedge clk);
    MDUEN = 1'b0; MDUCtrl = 3'd0; A = $urandom; B = $urandom;
    busy_n  = 0;
    hold_ok = 1'b1;
    while (Busy === 1'b1 && busy_n < 100) begin
      busy_n++;
      if (HI !== m_hi || LO !== m_lo) hold_ok = 1'b0;
      if (inject_mtlo && busy_n == 2) begin
        MDUEN = 1'b1; MDUCtrl = 3'd6; A = 32'hDEAD_BEEF;
      end else begin
        MDUEN = 1'b0; MDUCtrl = 3'd0;
      end
      @(negedge clk);
    end
    MDUEN = 1'b0; MDUCtrl = 3'd0;
    check("busy_len", 64'(busy_n), 64'(cycles));
    check("hold_during_busy", 64'(hold_ok), 64'd1);
    want = sb_q.pop_front();
    check("hilo_result", {HI, LO}, want);
    if (inject_mtlo) check("lo_not_injected", 64'(LO == 32'hDEAD_BEEF), 64'd0);
    m_hi = want[63:32];
    m_lo = want[31:0];
  endtask

  task automatic mt_op(input logic [2:0] ctrl, input logic [31:0] a);
    logic [63:0] want;
    sb_q.push_back((ctrl == 3'd5) ? {a, m_lo} : {m_hi, a});
    @(negedge clk);
    MDUEN = 1'b1; MDUCtrl = ctrl; A = a; Cancel = 1'b0;
    @(negedge clk);
    MDUEN = 1'b0; MDUCtrl = 3'd0; A = $urandom;
    check("mt_busy", 64'(Busy), 64'd0);
    want = sb_q.pop_front();
    check("mt_hilo", {HI, LO}, want);
    m_hi = want[63:32];
    m_lo = want[31:0];
    @(negedge clk);
    check("mt_busy_after", 64'(Busy), 64'd0);
  endtask

  task automatic cancel_op();
    bit busy_seen;
    @(negedge clk);
    MDUEN = 1'b1; MDUCtrl = 3'd1; A = 32'h0000_0123; B = 32'h0000_0456; Cancel = 1'b1;
    @(negedge clk);
    MDUEN = 1'b0; MDUCtrl = 3'd0; Cancel = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (Busy !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    check("cancel_busy", 64'(busy_seen), 64'd0);
    check("cancel_hilo", {HI, LO}, {m_hi, m_lo});
  endtask

  task automatic reset_mid_div();
    logic [63:0] dropped;
    sb_q.push_back(model_result(3'd3, 32'h0000_1000, 32'h0000_0007));
    @(negedge clk);
    MDUEN = 1'b1; MDUCtrl = 3'd3; A = 32'h0000_1000; B = 32'h0000_0007;
    @(negedge clk);
    MDUEN = 1'b0; MDUCtrl = 3'd0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("pre_reset_busy", 64'(Busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(Busy), 64'd0);
    check("async_rst_hilo", {HI, LO}, 64'd0);
    dropped = sb_q.pop_front();
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(Busy), 64'd0);
    check("post_rst_hilo", {HI, LO}, 64'd0);
    if (dropped == 64'd0) $display("note: dropped div result was zero");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; MDUEN = 1'b0; MDUCtrl = 3'd0; Cancel = 1'b0;
    A = 32'd0; B = 32'd0;
    #12;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    mdu_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
    mdu_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("multu_const", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
    mdu_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    check("div_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    mdu_op(3'd4, 32'h0000_0007, 32'h0000_0000, 1'b0);
    check("divu_zero_const", {HI, LO}, 64'h0000_0007_FFFF_FFFF);
    mdu_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);
    mdu_op(3'd3, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0);
    mdu_op(3'd4, 32'hF000_0001, 32'h0000_0010, 1'b0);
    mdu_op(3'd3, 32'h0000_0005, 32'h0000_0000, 1'b0);

    mt_op(3'd5, 32'h1234_5678);
    mt_op(3'd6, 32'hCAFE_BABE);

    cancel_op();

    mdu_op(3'd1, 32'h0001_0003, 32'hFFFE_0005, 1'b1);

    reset_mid_div();
    mdu_op(3'd2, 32'd3, 32'd4, 1'b0);
    check("post_rst_multu", {HI, LO}, 64'h0000_0000_0000_000C);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra, rb;
      logic [2:0]  rc;
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      rc = 3'(1 + (i % 4));
      mdu_op(rc, ra, rb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
